// File: rtl/bsg_gateway_chip_wh_mem_responder.sv
// Far-end wormhole memory responder: receives read/write request packets on one
// link, services them from a local flop-array memory and returns a response packet.
module bsg_gateway_chip_wh_mem_responder #(
  parameter int flit_width_p = 32,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 4,
  parameter int cord_width_p = 7,
  parameter int els_p        = 256,
  localparam int link_width_lp = flit_width_p + 2
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [cord_width_p-1:0]  my_cord_i,
  input  logic [link_width_lp-1:0] link_i,
  output logic [link_width_lp-1:0] link_o
);

  localparam int addr_w_lp = $clog2(els_p);
  localparam int len_lo_lp = cord_width_p;
  localparam int cid_lo_lp = len_lo_lp + len_width_p;
  localparam int src_lo_lp = cid_lo_lp + cid_width_p;
  localparam int op_lo_lp  = src_lo_lp + cord_width_p;
  localparam int cnt_lo_lp = op_lo_lp + 2;

  typedef enum logic [2:0] {
    RECV_HDR, RECV_ADDR, RECV_DATA, DRAIN, SEND_HDR, SEND_DATA
  } state_e;

  // Handshake: a flit moves on a clock edge where its valid and the opposite
  // side's ready_and_rev are both high; valid never waits on ready.
  logic                    in_v, in_ready, in_fire;
  logic                    out_v, out_ready, out_fire;
  logic [flit_width_p-1:0] in_data, out_data, rsp_hdr;
  logic [len_width_p-1:0]  in_len;
  logic [1:0]              in_op;

  state_e                  state_q, state_d;
  logic [cid_width_p-1:0]  cid_q, cid_d;
  logic [cord_width_p-1:0] src_q, src_d;
  logic [1:0]              op_q, op_d;
  logic [len_width_p-1:0]  len_q, len_d, count_q, count_d, rem_q, rem_d;
  logic [addr_w_lp-1:0]    addr_q, addr_d, start_q, start_d;
  logic                    err_q, err_d;
  logic                    mem_we;
  logic [flit_width_p-1:0] mem_q [els_p];

  assign in_v      = link_i[flit_width_p+1];
  assign in_data   = link_i[flit_width_p:1];
  assign out_ready = link_i[0];
  assign in_len    = in_data[len_lo_lp +: len_width_p];
  assign in_op     = in_data[op_lo_lp +: 2];

  assign in_ready = reset_n_i && (state_q inside {RECV_HDR, RECV_ADDR, RECV_DATA, DRAIN});
  assign out_v    = reset_n_i && (state_q inside {SEND_HDR, SEND_DATA});
  assign in_fire  = in_v & in_ready;
  assign out_fire = out_v & out_ready;
  assign link_o   = {out_v, out_data, in_ready};

  always_comb begin
    rsp_hdr = '0;
    rsp_hdr[0 +: cord_width_p]         = src_q;
    rsp_hdr[src_lo_lp +: cord_width_p] = my_cord_i;
    rsp_hdr[cid_lo_lp +: cid_width_p]  = cid_q;
    if (err_q) begin
      rsp_hdr[op_lo_lp +: 2] = 2'b11;
    end else if (op_q == 2'b00) begin
      rsp_hdr[len_lo_lp +: len_width_p] = count_q;
    end else begin
      rsp_hdr[op_lo_lp +: 2] = 2'b01;
    end
  end

  always_comb begin
    state_d  = state_q;
    cid_d    = cid_q;
    src_d    = src_q;
    op_d     = op_q;
    len_d    = len_q;
    count_d  = count_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    start_d  = start_q;
    err_d    = err_q;
    mem_we   = 1'b0;
    out_data = '0;
    case (state_q)
      RECV_HDR: if (in_fire) begin
        cid_d   = in_data[cid_lo_lp +: cid_width_p];
        src_d   = in_data[src_lo_lp +: cord_width_p];
        op_d    = in_op;
        len_d   = in_len;
        count_d = in_data[cnt_lo_lp +: len_width_p];
        err_d   = 1'b0;
        if (in_len == '0) begin
          err_d   = 1'b1;
          state_d = SEND_HDR;
        end else if (in_op[1]) begin
          err_d   = 1'b1;
          rem_d   = in_len;
          state_d = DRAIN;
        end else begin
          state_d = RECV_ADDR;
        end
      end
      RECV_ADDR: if (in_fire) begin
        addr_d  = in_data[addr_w_lp-1:0];
        start_d = in_data[addr_w_lp-1:0];
        rem_d   = len_q - len_width_p'(1);
        if (len_q > len_width_p'(1)) begin
          // A read carries no payload, so extra flits mark it malformed.
          err_d   = (op_q == 2'b00);
          state_d = (op_q == 2'b00) ? DRAIN : RECV_DATA;
        end else begin
          state_d = SEND_HDR;
        end
      end
      RECV_DATA: if (in_fire) begin
        mem_we = 1'b1;
        addr_d = addr_q + addr_w_lp'(1);
        rem_d  = rem_q - len_width_p'(1);
        if (rem_q == len_width_p'(1)) state_d = SEND_HDR;
      end
      DRAIN: if (in_fire) begin
        rem_d = rem_q - len_width_p'(1);
        if (rem_q == len_width_p'(1)) state_d = SEND_HDR;
      end
      SEND_HDR: begin
        out_data = rsp_hdr;
        if (out_fire) begin
          if (!err_q && op_q == 2'b00 && count_q != '0) begin
            addr_d  = start_q;
            rem_d   = count_q;
            state_d = SEND_DATA;
          end else begin
            state_d = RECV_HDR;
          end
        end
      end
      SEND_DATA: begin
        out_data = mem_q[addr_q];
        if (out_fire) begin
          addr_d = addr_q + addr_w_lp'(1);
          rem_d  = rem_q - len_width_p'(1);
          if (rem_q == len_width_p'(1)) state_d = RECV_HDR;
        end
      end
      default: state_d = RECV_HDR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= RECV_HDR;
      cid_q   <= '0;
      src_q   <= '0;
      op_q    <= '0;
      len_q   <= '0;
      count_q <= '0;
      rem_q   <= '0;
      addr_q  <= '0;
      start_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cid_q   <= cid_d;
      src_q   <= src_d;
      op_q    <= op_d;
      len_q   <= len_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset so a burst cut short by reset is retained.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[addr_q] <= in_data;
  end

endmodule

// File: tb/tb_bsg_gateway_chip_wh_mem_responder.sv
// Bench for the wormhole memory responder: a table of request packets, a memory
// model and an expected-flit queue checked by an output monitor.
module tb_bsg_gateway_chip_wh_mem_responder;
  localparam int W  = 32;
  localparam int LW = W + 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [6:0]    my_cord;
  logic [LW-1:0] link_i, link_o;
  logic          in_v, resp_ready;
  logic [W-1:0]  in_data;
  logic          out_v, out_ready;
  logic [W-1:0]  out_data;

  always #5 clk = ~clk;

  assign link_i    = {in_v, in_data, resp_ready};
  assign out_v     = link_o[W+1];
  assign out_data  = link_o[W:1];
  assign out_ready = link_o[0];

  bsg_gateway_chip_wh_mem_responder dut (
    .clk_i(clk), .reset_n_i(reset_n), .my_cord_i(my_cord),
    .link_i(link_i), .link_o(link_o)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [3:0]  len;
    logic [3:0]  count;
    logic [6:0]  src;
    logic [3:0]  cid;
    logic [6:0]  mcord;
    logic [31:0] addr;
    logic [31:0] wbase;
    logic [1:0]  exp_op;
    logic [3:0]  exp_len;
  } rec_t;

  int           checks, failures;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_mem[256];
  int           cyc;
  bit           rand_ready;
  int           xfer_n, first_cyc, last_cyc;
  rec_t         tbl[14];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic [6:0] dest, input logic [3:0] len,
                                         input logic [3:0] cid, input logic [6:0] src,
                                         input logic [1:0] op, input logic [3:0] count);
    return {4'b0, count, op, src, cid, len, dest};
  endfunction

  // Output monitor: picks the response-side ready, then scores the flit that
  // will transfer on the coming rising edge.
  initial begin
    logic         stalled;
    logic [W-1:0] held;
    logic [W-1:0] exp;
    stalled    = 1'b0;
    held       = '0;
    resp_ready = 1'b1;
    forever begin
      @(negedge clk);
      resp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_v) chk("ready_low_in_send", out_ready, 1'b0);
      if (out_v && stalled) chk("stall_stable", out_data, held);
      if (out_v && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", out_data, 32'hxxxx_xxxx);
        end else begin
          exp = exp_q.pop_front();
          chk("rsp_flit", out_data, exp);
        end
        if (xfer_n == 0) first_cyc = cyc;
        last_cyc = cyc;
        xfer_n++;
      end
      stalled = out_v && !resp_ready;
      held    = out_data;
    end
  end

  task automatic send_flit(input logic [W-1:0] d);
    int n;
    n = 0;
    in_v    = 1'b1;
    in_data = d;
    while (!out_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!out_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_v = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Queue the expected response, update the memory model, drive the packet.
  task automatic queue_and_send(input rec_t r, output int ndata);
    logic [7:0] a;
    my_cord = r.mcord;
    xfer_n  = 0;
    exp_q.push_back(mk_hdr(r.src, r.exp_len, r.cid, r.mcord, r.exp_op, 4'd0));
    ndata = (r.exp_op == 2'b00) ? int'(r.exp_len) : 0;
    for (int i = 0; i < ndata; i++) begin
      a = r.addr[7:0] + 8'(i);
      exp_q.push_back(model_mem[a]);
    end
    if (r.op == 2'b01 && r.len > 4'd1) begin
      for (int i = 1; i < int'(r.len); i++) begin
        a = r.addr[7:0] + 8'(i - 1);
        model_mem[a] = r.wbase + 32'(i - 1);
      end
    end
    send_flit(mk_hdr(r.mcord, r.len, r.cid, r.src, r.op, r.count));
    for (int i = 0; i < int'(r.len); i++)
      send_flit(i == 0 ? r.addr : r.wbase + 32'(i - 1));
  endtask

  task automatic run_rec(input rec_t r);
    int ndata;
    queue_and_send(r, ndata);
    chk("rsp_latency", out_v, 1'b1);
    wait_idle();
    chk("rsp_flit_count", xfer_n, 1 + ndata);
    if (!rand_ready && xfer_n > 0) chk("back_to_back", last_cyc - first_cyc, xfer_n - 1);
  endtask

  initial begin
    int   ndata, n, n_before;
    rec_t bp;
    checks = 0; failures = 0; cyc = 0; xfer_n = 0; first_cyc = 0; last_cyc = 0;
    rand_ready = 1'b0;
    reset_n = 1'b0; in_v = 1'b0; in_data = '0; my_cord = 7'h11;

    //            op     len   cnt   src    cid   mcord  addr          wbase          eop    elen
    tbl[0]  = '{2'b01, 4'd4, 4'd0, 7'h05, 4'd2, 7'h11, 32'h10,       32'hA,         2'b01, 4'd0};
    tbl[1]  = '{2'b00, 4'd1, 4'd3, 7'h05, 4'd2, 7'h11, 32'h10,       32'h0,         2'b00, 4'd3};
    tbl[2]  = '{2'b01, 4'd3, 4'd0, 7'h22, 4'd7, 7'h11, 32'hFF,       32'h100,       2'b01, 4'd0};
    tbl[3]  = '{2'b00, 4'd1, 4'd2, 7'h22, 4'd7, 7'h11, 32'hFF,       32'h0,         2'b00, 4'd2};
    tbl[4]  = '{2'b10, 4'd3, 4'd0, 7'h33, 4'd1, 7'h11, 32'h10,       32'hDEAD_0000, 2'b11, 4'd0};
    tbl[5]  = '{2'b00, 4'd1, 4'd1, 7'h33, 4'd1, 7'h11, 32'h10,       32'h0,         2'b00, 4'd1};
    tbl[6]  = '{2'b00, 4'd0, 4'd3, 7'h44, 4'd3, 7'h2A, 32'h0,        32'h0,         2'b11, 4'd0};
    tbl[7]  = '{2'b00, 4'd2, 4'd1, 7'h45, 4'd4, 7'h2A, 32'h10,       32'h77,        2'b11, 4'd0};
    tbl[8]  = '{2'b00, 4'd1, 4'd0, 7'h46, 4'd5, 7'h2A, 32'h10,       32'h0,         2'b00, 4'd0};
    tbl[9]  = '{2'b01, 4'd6, 4'd0, 7'h50, 4'd6, 7'h11, 32'h40,       32'h1234_5000, 2'b01, 4'd0};
    tbl[10] = '{2'b00, 4'd1, 4'd5, 7'h50, 4'd6, 7'h11, 32'hFFFF_FF40, 32'h0,        2'b00, 4'd5};
    tbl[11] = '{2'b11, 4'd1, 4'd0, 7'h51, 4'd8, 7'h11, 32'h10,       32'h0,         2'b11, 4'd0};
    tbl[12] = '{2'b01, 4'd2, 4'd0, 7'h52, 4'd9, 7'h11, 32'h10,       32'h55,        2'b01, 4'd0};
    tbl[13] = '{2'b00, 4'd1, 4'd2, 7'h52, 4'd9, 7'h11, 32'h10,       32'h0,         2'b00, 4'd2};

    repeat (3) @(negedge clk);
    chk("rst_v", out_v, 1'b0);
    chk("rst_ready", out_ready, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", out_ready, 1'b1);
    chk("post_rst_v", out_v, 1'b0);

    foreach (tbl[i]) run_rec(tbl[i]);

    // Random response backpressure on a 5-word read.
    bp = '{2'b00, 4'd1, 4'd5, 7'h60, 4'd9, 7'h11, 32'h40, 32'h0, 2'b00, 4'd5};
    rand_ready = 1'b1;
    run_rec(bp);

    // Reset in the middle of the returned burst.
    queue_and_send(bp, ndata);
    n = 0;
    while (xfer_n < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_burst_reached", (xfer_n >= 2), 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_v", out_v, 1'b0);
    chk("rst_mid_ready", out_ready, 1'b0);
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    rand_ready = 1'b0;
    n_before   = xfer_n;
    repeat (10) @(negedge clk);
    chk("no_flit_after_rst", xfer_n, n_before);

    run_rec(bp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_gateway_chip_wh_mem_responder.md
# bsg_gateway_chip_wh_mem_responder

Wormhole memory responder. It terminates one concentrated wormhole link on the gateway side, opposite the ASIC-side memory-link initiators. It decodes read/write request packets, services them from a local flop-array memory, and returns response packets with source and destination coordinates swapped. The bench uses it as the far-end model of the chip's off-chip memory path.

## Interface
Parameters:
- flit_width_p, 32, wormhole flit width.
- len_width_p, 4, packet length field width (flits after header).
- cid_width_p, 4, concentrator id field width.
- cord_width_p, 7, coordinate field width.
- els_p, 256, memory depth in flit-wide words; must be a power of two.

Ports (link width = `bsg_ready_and_link_sif_width(flit_width_p)`):
- clk_i, in, 1, sole clock.
- reset_n_i, in, 1, synchronous, active-low reset.
- my_cord_i, in, cord_width_p, this node's coordinate; placed in the response src field.
- link_i, in, link width, {v, data, ready_and_rev}: request flits plus the ready for response flits.
- link_o, out, link width, {v, data, ready_and_rev}: response flits plus the ready for request flits.

Header flit fields, LSB first:
- dest_cord [cord_width_p].
- len [len_width_p].
- cid [cid_width_p].
- src_cord [cord_width_p].
- op [2]: 00 = read, 01 = write, 1x = illegal.
- count [len_width_p]: read word count.
- Remaining bits are zero.

## Operation
- Input flit transfers when link_i.v & link_o.ready_and_rev. Output flit transfers when link_o.v & link_i.ready_and_rev.
- FSM states: RECV_HDR, RECV_ADDR, RECV_DATA, DRAIN, SEND_HDR, SEND_DATA.
- RECV_HDR: on accept, latch cid, src_cord, op, len and count.
  - len==0 -> SEND_HDR with error.
  - op illegal -> DRAIN.
  - Otherwise -> RECV_ADDR.
- RECV_ADDR: on accept, latch addr = data[lg(els_p)-1:0]; upper bits are ignored. Load rem = len-1.
  - Write with rem>0 -> RECV_DATA.
  - Otherwise -> SEND_HDR.
  - Read with len>1 sets the error flag; the extra flits are drained through DRAIN before SEND_HDR.
- RECV_DATA: each accepted flit writes mem[addr]; then addr++ (mod els_p) and rem--. After the flit with rem==1 -> SEND_HDR.
- DRAIN: accept and discard flits until the len payload flits have all been consumed -> SEND_HDR with error.
- SEND_HDR: drive a header with:
  - dest = latched src_cord, src = my_cord_i, cid = latched cid.
  - Read: op=00, len=count.
  - Write: op=01, len=0.
  - Error: op=11, len=0.
- After the header transfers:
  - Read with count>0 -> SEND_DATA, with addr reset to the latched start address.
  - Otherwise -> RECV_HDR.
- SEND_DATA: data = mem[addr] (combinational read). On each transfer, addr++ (mod els_p) and rem--. After the last flit -> RECV_HDR.
- A write of the same address within one packet: the last write wins.
- Memory contents are not reset.

## Timing
- Reset (reset_n_i==0 at a clk_i edge) sets:
  - State = RECV_HDR; all counters and flags cleared.
  - link_o.v = 0 and link_o.ready_and_rev = 0 during reset.
  - link_o.ready_and_rev = 1 from the first cycle after reset deasserts.
- Reset mid-packet abandons the packet with no response. A partially written burst stays in memory.
- link_o.ready_and_rev = 1 exactly in RECV_HDR, RECV_ADDR, RECV_DATA and DRAIN; 0 in the SEND states.
- link_o.v = 1 exactly in the SEND states. It is independent of link_i.ready_and_rev, and data is held stable while v=1 and no transfer occurs.
- Throughput: one flit per cycle in each phase. There is no overlap between receiving and sending.
- Latency: the response header is valid in the cycle after the last request flit is accepted.
- A write flit is visible to a read request that starts in the following packet.

## Test plan
- Reset then idle:
  - During reset: link_o.v=0, ready=0.
  - The cycle after deassert: ready=1, v=0.
- Write 3 words 0xA, 0xB, 0xC at addr 0x10 (len=4, src=0x05, cid=2, my_cord_i=0x11) -> one header: dest=0x05, src=0x11, cid=2, op=01, len=0.
- Read count=3 at 0x10 (len=1) -> header op=00, len=3, then data 0xA, 0xB, 0xC on back-to-back cycles when link_i.ready_and_rev is held high.
- Wrap-around: write 2 words at 0xFF (els_p=256), then read count=2 at 0xFF -> returns the words from addresses 0xFF and 0x00.
- Illegal op=10 with len=3 -> all 3 payload flits accepted, then header op=11, len=0. A following read still succeeds.
- Backpressure: toggle link_i.ready_and_rev randomly during a count=5 read -> exactly 6 flits in order, data stable while stalled, link_o.ready_and_rev=0 throughout. Assert reset mid-burst -> v drops the next cycle and no further flits are sent.
